// File: rtl/nco_sweep_ctrl.sv
// Stepped linear chirp sequencer feeding the FM sine NCO frequency control word.
// Up-ramp (mode 0) or continuous triangle (mode 1) with per-value dwell and endpoint clamping.
module nco_sweep_ctrl #(
  parameter int W       = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [W-1:0]       cfg_f_start,
  input  logic [W-1:0]       cfg_f_stop,
  input  logic [W-1:0]       cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_mode,
  output logic [W-1:0]       ctrl,
  output logic               busy,
  output logic               step_tick,
  output logic               done,
  output logic               err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_n;
  logic               dir_down_q, dir_down_n;
  logic [DWELL_W-1:0] cnt_q, cnt_n;
  logic [W-1:0]       ctrl_q, ctrl_n;
  logic [W-1:0]       sh_f_start_q, sh_f_start_n;
  logic [W-1:0]       sh_f_stop_q, sh_f_stop_n;
  logic [W-1:0]       sh_step_q, sh_step_n;
  logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_n;
  logic               sh_mode_q, sh_mode_n;
  logic               busy_q, step_tick_q, done_q, err_q;
  logic               step_tick_n, done_n, err_n;
  logic               cfg_bad;

  // Up-step saturates at the stop word; the W+1 bit sum catches carry out.
  function automatic logic [W-1:0] step_up(input logic [W-1:0] cur,
                                           input logic [W-1:0] inc,
                                           input logic [W-1:0] lim);
    logic [W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum >= {1'b0, lim}) return lim;
    return sum[W-1:0];
  endfunction

  // Down-step saturates at the start word without borrowing below it.
  function automatic logic [W-1:0] step_down(input logic [W-1:0] cur,
                                             input logic [W-1:0] dec,
                                             input logic [W-1:0] lim);
    if ((cur - lim) <= dec) return lim;
    return cur - dec;
  endfunction

  assign cfg_bad = (cfg_step == '0) || (cfg_f_stop <= cfg_f_start);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dir_down_q   <= 1'b0;
      cnt_q        <= '0;
      ctrl_q       <= '0;
      sh_f_start_q <= '0;
      sh_f_stop_q  <= '0;
      sh_step_q    <= '0;
      sh_dwell_q   <= '0;
      sh_mode_q    <= 1'b0;
      busy_q       <= 1'b0;
      step_tick_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      dir_down_q   <= dir_down_n;
      cnt_q        <= cnt_n;
      ctrl_q       <= ctrl_n;
      sh_f_start_q <= sh_f_start_n;
      sh_f_stop_q  <= sh_f_stop_n;
      sh_step_q    <= sh_step_n;
      sh_dwell_q   <= sh_dwell_n;
      sh_mode_q    <= sh_mode_n;
      busy_q       <= (state_n == RUN);
      step_tick_q  <= step_tick_n;
      done_q       <= done_n;
      err_q        <= err_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    dir_down_n   = dir_down_q;
    cnt_n        = cnt_q;
    ctrl_n       = ctrl_q;
    sh_f_start_n = sh_f_start_q;
    sh_f_stop_n  = sh_f_stop_q;
    sh_step_n    = sh_step_q;
    sh_dwell_n   = sh_dwell_q;
    sh_mode_n    = sh_mode_q;
    step_tick_n  = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!abort && start) begin
          if (cfg_bad) begin
            err_n = 1'b1;
          end else begin
            sh_f_start_n = cfg_f_start;
            sh_f_stop_n  = cfg_f_stop;
            sh_step_n    = cfg_step;
            sh_dwell_n   = cfg_dwell;
            sh_mode_n    = cfg_mode;
            ctrl_n       = cfg_f_start;
            dir_down_n   = 1'b0;
            cnt_n        = cfg_dwell;
            step_tick_n  = 1'b1;
            state_n      = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt_q != '0) begin
          cnt_n = cnt_q - DWELL_W'(1);
        end else if (!dir_down_q && ctrl_q == sh_f_stop_q && !sh_mode_q) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          // Turnarounds flip direction and step away in the same expiry,
          // so endpoints are never held twice.
          step_tick_n = 1'b1;
          cnt_n       = sh_dwell_q;
          if (!dir_down_q) begin
            if (ctrl_q == sh_f_stop_q) begin
              dir_down_n = 1'b1;
              ctrl_n     = step_down(ctrl_q, sh_step_q, sh_f_start_q);
            end else begin
              ctrl_n = step_up(ctrl_q, sh_step_q, sh_f_stop_q);
            end
          end else begin
            if (ctrl_q == sh_f_start_q) begin
              dir_down_n = 1'b0;
              ctrl_n     = step_up(ctrl_q, sh_step_q, sh_f_stop_q);
            end else begin
              ctrl_n = step_down(ctrl_q, sh_step_q, sh_f_start_q);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ctrl      = ctrl_q;
  assign busy      = busy_q;
  assign step_tick = step_tick_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
